// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving an external montgomery core.
// Optional cycle counter guarded by MODEXP_CYCLE_CNT_EN (cycle_count tied 0 otherwise).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request, sampled only in IDLE with msg/r_mod_n/r2_mod_n/exponent/exp_len
//   busy, done      operation in flight / one-cycle completion pulse
//   result          x^e mod N, held until the next accepted start
//   mont_start      one-cycle issue pulse to the core
//   mont_a, mont_b  core operands, stable through issue and wait
//   mont_done       core completion, honoured only while waiting
//   mont_result     core product, captured with mont_done
//   cycle_count     cycles spent on the last operation
module modexp_sequencer #(
  parameter int WIDTH = 1024,
  parameter int EXP_W = 1024,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] r_mod_n,
  input  logic [WIDTH-1:0] r2_mod_n,
  input  logic [EXP_W-1:0] exponent,
  input  logic [LEN_W-1:0] exp_len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mont_start,
  output logic [WIDTH-1:0] mont_a,
  output logic [WIDTH-1:0] mont_b,
  input  logic             mont_done,
  input  logic [WIDTH-1:0] mont_result,
  output logic [31:0]      cycle_count
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    P_PRE,
    P_SQR,
    P_MUL,
    P_POST
  } phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [WIDTH-1:0]  msg_q, msg_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  r2_q, r2_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tz_q, tz_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  xt_q, xt_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [LEN_W-1:0]  t_sat;

  assign t_sat = (exp_len > LEN_W'(EXP_W)) ? LEN_W'(EXP_W) : exp_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= P_PRE;
      msg_q   <= '0;
      r_q     <= '0;
      r2_q    <= '0;
      exp_q   <= '0;
      idx_q   <= '0;
      tz_q    <= 1'b0;
      a_q     <= '0;
      xt_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      msg_q   <= msg_d;
      r_q     <= r_d;
      r2_q    <= r2_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      tz_q    <= tz_d;
      a_q     <= a_d;
      xt_q    <= xt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    msg_d      = msg_q;
    r_d        = r_q;
    r2_d       = r2_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    tz_d       = tz_q;
    a_d        = a_q;
    xt_d       = xt_q;
    res_d      = res_q;
    mont_start = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          msg_d   = msg;
          r_d     = r_mod_n;
          r2_d    = r2_mod_n;
          exp_d   = exponent;
          // t-1 wraps when t==0; tz_q routes PRE straight to POST then
          idx_d   = IW'(t_sat - LEN_W'(1));
          tz_d    = (t_sat == '0);
          phase_d = P_PRE;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mont_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (mont_done) begin
          state_d = S_ISSUE;
          unique case (phase_q)
            P_PRE: begin
              xt_d    = mont_result;
              a_d     = r_q;
              phase_d = tz_q ? P_POST : P_SQR;
            end
            P_SQR: begin
              a_d = mont_result;
              if (exp_q[idx_q]) begin
                phase_d = P_MUL;
              end else if (idx_q == '0) begin
                phase_d = P_POST;
              end else begin
                idx_d   = idx_q - IW'(1);
                phase_d = P_SQR;
              end
            end
            P_MUL: begin
              a_d = mont_result;
              if (idx_q == '0) begin
                phase_d = P_POST;
              end else begin
                idx_d   = idx_q - IW'(1);
                phase_d = P_SQR;
              end
            end
            P_POST: begin
              res_d   = mont_result;
              state_d = S_DONE;
            end
            default: ;
          endcase
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mont_a = a_q;
    mont_b = a_q;
    unique case (phase_q)
      P_PRE: begin
        mont_a = msg_q;
        mont_b = r2_q;
      end
      P_SQR: begin
        mont_a = a_q;
        mont_b = a_q;
      end
      P_MUL: begin
        mont_a = a_q;
        mont_b = xt_q;
      end
      P_POST: begin
        mont_a = a_q;
        mont_b = WIDTH'(1);
      end
      default: ;
    endcase
  end

  assign busy   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign result = res_q;

`ifdef MODEXP_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cc_q, cc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      cc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      cc_q  <= cc_d;
    end
  end

  // The DONE cycle itself is included in the reported figure.
  always_comb begin
    cnt_d = cnt_q;
    cc_d  = cc_q;
    if ((state_q == S_IDLE) && start) begin
      cnt_d = '0;
    end else if ((state_q != S_IDLE) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (state_q == S_DONE) begin
      cc_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    end
  end

  assign cycle_count = cc_q;
`else
  assign cycle_count = 32'h0;
`endif

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed bench for modexp_sequencer with a behavioural montgomery core.
// N=97, R=2^16, WIDTH=16, EXP_W=1024.
module tb_modexp_sequencer;

  localparam int WIDTH = 16;
  localparam int EXP_W = 1024;
  localparam int LEN_W = 11;
  localparam logic [63:0] N = 64'd97;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] msg = '0;
  logic [WIDTH-1:0] r_mod_n = '0;
  logic [WIDTH-1:0] r2_mod_n = '0;
  logic [EXP_W-1:0] exponent = '0;
  logic [LEN_W-1:0] exp_len = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             mont_start;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic             mont_done;
  logic [WIDTH-1:0] mont_result;
  logic [31:0]      cycle_count;

  modexp_sequencer #(
    .WIDTH(WIDTH),
    .EXP_W(EXP_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .msg(msg),
    .r_mod_n(r_mod_n),
    .r2_mod_n(r2_mod_n),
    .exponent(exponent),
    .exp_len(exp_len),
    .busy(busy),
    .done(done),
    .result(result),
    .mont_start(mont_start),
    .mont_a(mont_a),
    .mont_b(mont_b),
    .mont_done(mont_done),
    .mont_result(mont_result),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] rinv = 64'd1;
  logic [WIDTH-1:0] rmod;
  logic [WIDTH-1:0] r2;
  int          lat = 2;
  logic        extra_done = 1'b0;

  logic [7:0]       cd = '0;
  logic [WIDTH-1:0] pa = '0;
  logic [WIDTH-1:0] pb = '0;
  int               ops = 0;
  int               sqr_n = 0;
  logic [63:0]      code = '0;
  int               base = 0;
  int               sqr_base = 0;

  function automatic logic [WIDTH-1:0] mont(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [63:0] ri
  );
    logic [63:0] p;
    p = (64'(a) * 64'(b)) % N;
    p = (p * ri) % N;
    return p[WIDTH-1:0];
  endfunction

  function automatic logic [63:0] powmod(input logic [63:0] x, input int e);
    logic [63:0] r;
    r = 64'd1 % N;
    for (int k = 0; k < e; k++) r = (r * x) % N;
    return r;
  endfunction

  // 0=PRE 1=SQR 2=MUL 3=POST
  function automatic logic [1:0] kind_of(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] rr
  );
    if (b == WIDTH'(1)) return 2'd3;
    if (a == b) return 2'd1;
    if (a == x && b == rr) return 2'd0;
    return 2'd2;
  endfunction

  assign mont_done   = (cd == 8'd1) | extra_done;
  assign mont_result = mont(pa, pb, rinv);

  always @(posedge clk) begin
    if (reset) begin
      cd <= '0;
    end else if (mont_start) begin
      ops   <= ops + 1;
      sqr_n <= sqr_n + ((kind_of(mont_a, mont_b, msg, r2) == 2'd1) ? 1 : 0);
      code  <= {code[61:0], kind_of(mont_a, mont_b, msg, r2)};
      cd    <= lat[7:0];
      pa    <= mont_a;
      pb    <= mont_b;
    end else if (cd != 0) begin
      cd <= cd - 8'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic kick(
    input logic [WIDTH-1:0] x,
    input logic [EXP_W-1:0] e,
    input logic [LEN_W-1:0] len
  );
    msg      = x;
    r_mod_n  = rmod;
    r2_mod_n = r2;
    exponent = e;
    exp_len  = len;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    base     = ops;
    sqr_base = sqr_n;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    logic got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic wait_ops(input int n);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (ops - base >= n) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reach_op", 64'(got), 64'd1);
  endtask

  logic [17:0] exp_code;
  int          kinds [9] = '{0, 1, 2, 1, 1, 2, 1, 2, 3};

  initial begin
    rmod = WIDTH'(64'd65536 % N);
    r2   = WIDTH'((64'(rmod) * 64'(rmod)) % N);
    for (int k = 1; k < 97; k++) begin
      if (((64'(rmod) * 64'(k)) % N) == 64'd1) rinv = 64'(k);
    end
    exp_code = '0;
    for (int k = 0; k < 9; k++) exp_code = {exp_code[15:0], 2'(kinds[k])};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mont_start", 64'(mont_start), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    extra_done = 1'b1;
    @(posedge clk); #1;
    extra_done = 1'b0;
    check("idle_done_busy", 64'(busy), 64'd0);
    check("idle_done_mstart", 64'(mont_start), 64'd0);

    // e=1011, t=4
    lat = 2;
    kick(16'd5, EXP_W'(4'b1011), 11'd4);
    wait_done(300);
    check("t1_ops", 64'(ops - base), 64'd9);
    check("t1_order", 64'(code[17:0]), 64'(exp_code));
    check("t1_result", 64'(result), powmod(5, 11));

    // t=0
    kick(16'd5, EXP_W'(4'b1011), 11'd0);
    wait_done(300);
    check("t0_ops", 64'(ops - base), 64'd2);
    check("t0_result", 64'(result), 64'd1);

    // start while busy is ignored
    kick(16'd5, EXP_W'(4'b1011), 11'd4);
    wait_ops(2);
    msg     = 16'd7;
    exp_len = 11'd0;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    msg     = 16'd5;
    wait_done(300);
    check("rs_ops", 64'(ops - base), 64'd9);
    check("rs_order", 64'(code[17:0]), 64'(exp_code));
    check("rs_result", 64'(result), powmod(5, 11));

    // reset during MUL wait (third op)
    lat = 3;
    kick(16'd5, EXP_W'(4'b1011), 11'd4);
    wait_ops(3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_mstart", 64'(mont_start), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    kick(16'd3, EXP_W'(3'b101), 11'd3);
    wait_done(300);
    check("mr_fresh_ops", 64'(ops - base), 64'd7);
    check("mr_fresh_result", 64'(result), powmod(3, 5));

    // exp_len saturates to EXP_W
    lat = 1;
    kick(16'd5, '0, 11'd1100);
    wait_done(5000);
    check("sat_sqr", 64'(sqr_n - sqr_base), 64'd1024);
    check("sat_ops", 64'(ops - base), 64'd1026);
    check("sat_result", 64'(result), 64'd1);

    // cycle count, L=3, e=1, t=1
    lat = 3;
    kick(16'd5, EXP_W'(1), 11'd1);
    wait_done(300);
    check("cc_ops", 64'(ops - base), 64'd4);
    check("cc_result", 64'(result), powmod(5, 1));
`ifdef MODEXP_CYCLE_CNT_EN
    check("cc_value", 64'(cycle_count), 64'd17);
`else
    check("cc_value", 64'(cycle_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
